// File: rtl/chip8_alu_seq_pkg.sv
// Shared enums for the CHIP-8 8XYn ALU sequencer: ALU function codes,
// sequencer state encoding and the 8XYn operation codes.
package chip8_alu_seq_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned ALU_W   = 16;

  typedef enum logic [2:0] {
    ALU_f_OR,
    ALU_f_AND,
    ALU_f_XOR,
    ALU_f_ADD,
    ALU_f_MINUS,
    ALU_f_RSHIFT,
    ALU_f_LSHIFT
  } ALU_f;

  typedef enum logic [2:0] {
    IDLE,
    RD_X,
    RD_Y,
    LATCH_Y,
    EXEC,
    WB_RES,
    WB_FLAG,
    DONE
  } alu_seq_state_e;

  localparam logic [3:0] OPC_ALU = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_SUBN = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'hE;

  localparam logic [ADDR_W-1:0] VF_ADDR = 4'hF;

  function automatic logic op_legal(input logic [INSTR_W-1:0] ins);
    return (ins[15:12] == OPC_ALU) && ((ins[3:0] <= OP_SUBN) || (ins[3:0] == OP_SHL));
  endfunction

  function automatic logic op_has_flag(input logic [3:0] n);
    return (n == OP_ADD) || (n == OP_SUB) || (n == OP_SHR) || (n == OP_SUBN) || (n == OP_SHL);
  endfunction

endpackage

// File: rtl/chip8_alu_seq.sv
// CHIP-8 8XYn sequencer: reads Vx/Vy from a synchronous register file,
// drives an external ALU, then writes Vx and (for flag ops) VF.
module chip8_alu_seq
  import chip8_alu_seq_pkg::*;
(
  input  logic               cpu_clk,
  input  logic               reset,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [ADDR_W-1:0]  reg_addr,
  input  logic [DATA_W-1:0]  reg_rdata,
  output logic [DATA_W-1:0]  reg_wdata,
  output logic               reg_we,
  output logic [ALU_W-1:0]   alu_in1,
  output logic [ALU_W-1:0]   alu_in2,
  output ALU_f               alu_sel,
  input  logic [ALU_W-1:0]   alu_out,
  input  logic               alu_carry
);

  alu_seq_state_e state, state_nxt;
  logic               pend;
  logic               bad;
  logic [INSTR_W-1:0] ins;
  logic [DATA_W-1:0]  vx, vy, res;
  logic               flag;
  logic [DATA_W-1:0]  res_c;
  logic               flag_c;
  logic               unused_alu_hi;

  assign unused_alu_hi = ^alu_out[ALU_W-1:DATA_W];

  // The accepted start spends one IDLE cycle (pend) decoding the latched opcode.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state <= IDLE;
      pend  <= 1'b0;
      bad   <= 1'b0;
      ins   <= '0;
      vx    <= '0;
      vy    <= '0;
      res   <= '0;
      flag  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        pend <= start && !pend;
        if (start && !pend) ins <= instr;
        if (pend) bad <= !op_legal(ins);
      end
      if (state == RD_Y)    vx <= reg_rdata;
      if (state == LATCH_Y) vy <= reg_rdata;
      if (state == EXEC) begin
        res  <= res_c;
        flag <= flag_c;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pend) state_nxt = op_legal(ins) ? RD_X : DONE;
      RD_X:    state_nxt = RD_Y;
      RD_Y:    state_nxt = LATCH_Y;
      LATCH_Y: state_nxt = EXEC;
      EXEC:    state_nxt = WB_RES;
      WB_RES:  state_nxt = op_has_flag(ins[3:0]) ? WB_FLAG : DONE;
      WB_FLAG: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = pend || (state != IDLE);
    done      = (state == DONE);
    err       = (state == DONE) && bad;
    reg_addr  = '0;
    reg_wdata = '0;
    reg_we    = 1'b0;
    alu_in1   = '0;
    alu_in2   = '0;
    alu_sel   = ALU_f_OR;
    res_c     = '0;
    flag_c    = 1'b0;
    case (state)
      RD_X: reg_addr = ins[11:8];
      RD_Y: reg_addr = ins[7:4];
      EXEC: begin
        alu_in1 = ALU_W'(vx);
        alu_in2 = ALU_W'(vy);
        res_c   = alu_out[DATA_W-1:0];
        case (ins[3:0])
          OP_LD: begin
            alu_in1 = '0;
            alu_in2 = '0;
            res_c   = vy;
          end
          OP_OR:  alu_sel = ALU_f_OR;
          OP_AND: alu_sel = ALU_f_AND;
          OP_XOR: alu_sel = ALU_f_XOR;
          OP_ADD: begin
            alu_sel = ALU_f_ADD;
            flag_c  = alu_carry;
          end
          OP_SUB: begin
            alu_sel = ALU_f_MINUS;
            flag_c  = (vx >= vy);
          end
          OP_SHR: begin
            alu_sel = ALU_f_RSHIFT;
            alu_in2 = ALU_W'(1);
            flag_c  = vx[0];
          end
          OP_SUBN: begin
            alu_sel = ALU_f_MINUS;
            alu_in1 = ALU_W'(vy);
            alu_in2 = ALU_W'(vx);
            flag_c  = (vy >= vx);
          end
          OP_SHL: begin
            alu_sel = ALU_f_LSHIFT;
            alu_in2 = ALU_W'(1);
            flag_c  = vx[DATA_W-1];
          end
          default: ;
        endcase
      end
      WB_RES: begin
        reg_we    = 1'b1;
        reg_addr  = ins[11:8];
        reg_wdata = res;
      end
      WB_FLAG: begin
        reg_we    = 1'b1;
        reg_addr  = VF_ADDR;
        reg_wdata = DATA_W'(flag);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_chip8_alu_seq.sv
// Bench for chip8_alu_seq: register file and ALU models around the DUT,
// directed cases plus random 8XYn opcodes checked against a reference model.
module tb_chip8_alu_seq;
  import chip8_alu_seq_pkg::*;

  logic        cpu_clk = 1'b0;
  logic        reset, start;
  logic [15:0] instr;
  logic        busy, done, err, reg_we, alu_carry;
  logic [3:0]  reg_addr;
  logic [7:0]  reg_rdata, reg_wdata;
  logic [15:0] alu_in1, alu_in2, alu_out;
  ALU_f        alu_sel;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  rf [16];
  logic [7:0]  rf_init [16];
  logic        load = 1'b0;
  logic [11:0] wr_q [$];

  logic [7:0]  m_regs [16];
  logic [11:0] exp_wr [$];
  int          exp_lat, exp_err, exp_n, exp_in1;
  ALU_f        exp_sel;

  chip8_alu_seq dut (
    .cpu_clk(cpu_clk), .reset(reset), .start(start), .instr(instr),
    .busy(busy), .done(done), .err(err),
    .reg_addr(reg_addr), .reg_rdata(reg_rdata), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Synchronous-read register file with a write log.
  always @(posedge cpu_clk) begin
    reg_rdata <= rf[reg_addr];
    if (load) rf <= rf_init;
    else if (reg_we) begin
      rf[reg_addr] <= reg_wdata;
      wr_q.push_back({reg_addr, reg_wdata});
    end
  end

  // Combinational ALU; carry is the 8-bit add carry.
  always_comb begin
    alu_out   = '0;
    alu_carry = 1'b0;
    case (alu_sel)
      ALU_f_OR:     alu_out = alu_in1 | alu_in2;
      ALU_f_AND:    alu_out = alu_in1 & alu_in2;
      ALU_f_XOR:    alu_out = alu_in1 ^ alu_in2;
      ALU_f_ADD: begin
        alu_out   = alu_in1 + alu_in2;
        alu_carry = ({1'b0, alu_in1[7:0]} + {1'b0, alu_in2[7:0]}) > 9'd255;
      end
      ALU_f_MINUS:  alu_out = alu_in1 - alu_in2;
      ALU_f_RSHIFT: alu_out = alu_in1 >> alu_in2;
      ALU_f_LSHIFT: alu_out = alu_in1 << alu_in2;
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: expected writes, latency and final register contents.
  task automatic model_op(input logic [15:0] ins);
    int x, y, n, vx, vy, res, f;
    bit flagop;
    x = int'(ins[11:8]); y = int'(ins[7:4]); n = int'(ins[3:0]);
    exp_wr.delete();
    exp_n = n; exp_err = 0; f = 0; flagop = 0; res = 0;
    exp_sel = ALU_f_OR;
    if (ins[15:12] != 4'h8 || !(n <= 7 || n == 14)) begin
      exp_err = 1; exp_lat = 1;
      return;
    end
    vx = int'(m_regs[x]); vy = int'(m_regs[y]);
    exp_in1 = (n == 7) ? vy : vx;
    case (n)
      0: res = vy;
      1: begin res = vx | vy; exp_sel = ALU_f_OR;  end
      2: begin res = vx & vy; exp_sel = ALU_f_AND; end
      3: begin res = vx ^ vy; exp_sel = ALU_f_XOR; end
      4: begin res = vx + vy; f = (res > 255) ? 1 : 0; flagop = 1; exp_sel = ALU_f_ADD; end
      5: begin res = vx - vy; f = (vx >= vy) ? 1 : 0; flagop = 1; exp_sel = ALU_f_MINUS; end
      6: begin res = vx / 2;  f = vx % 2; flagop = 1; exp_sel = ALU_f_RSHIFT; end
      7: begin res = vy - vx; f = (vy >= vx) ? 1 : 0; flagop = 1; exp_sel = ALU_f_MINUS; end
      default: begin res = vx * 2; f = vx / 128; flagop = 1; exp_sel = ALU_f_LSHIFT; end
    endcase
    res = res & 255;
    exp_wr.push_back(12'(x * 256 + res));
    m_regs[x] = 8'(res);
    if (flagop) begin
      exp_wr.push_back(12'(15 * 256 + f));
      m_regs[15] = 8'(f);
    end
    exp_lat = flagop ? 7 : 6;
  endtask

  task automatic load_rf();
    m_regs = rf_init;
    @(negedge cpu_clk) load = 1'b1;
    @(posedge cpu_clk) #1 load = 1'b0;
  endtask

  // mode 0: plain; 1: start pulsed during RD_Y; 2: reset asserted in EXEC.
  task automatic run_op(input logic [15:0] ins, input int mode);
    int base, lat;
    logic [7:0] saved [16];
    saved = m_regs;
    base = wr_q.size();
    model_op(ins);
    @(negedge cpu_clk);
    start = 1'b1; instr = ins;
    @(posedge cpu_clk) #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge cpu_clk) #1;
      if (k == 2 && exp_err == 0) begin
        check("alu_idle_in1", 32'(alu_in1), 32'd0);
        check("alu_idle_sel", 32'(alu_sel), 32'(ALU_f_OR));
        if (mode == 1) begin start = 1'b1; instr = 16'h8014; end
      end
      if (k == 3 && mode == 1) start = 1'b0;
      if (k == 4 && exp_err == 0) begin
        if (exp_n != 0) begin
          check("exec_sel", 32'(alu_sel), 32'(exp_sel));
          check("exec_in1", 32'(alu_in1), 32'(exp_in1));
        end
        if (mode == 2) reset = 1'b1;
      end
      if (k == 5 && mode == 2) begin
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_we", 32'(reg_we), 32'd0);
        reset = 1'b0;
        break;
      end
      if (done) begin lat = k; break; end
    end
    if (mode == 2) begin
      m_regs = saved;
      repeat (3) @(posedge cpu_clk);
      #1 check("abort_no_writes", 32'(wr_q.size() - base), 32'd0);
      check("abort_rx_kept", 32'(rf[ins[11:8]]), 32'(m_regs[ins[11:8]]));
      return;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("err", 32'(err), 32'(exp_err));
    @(posedge cpu_clk) #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_clear", 32'(busy), 32'd0);
    check("write_count", 32'(wr_q.size() - base), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && base + i < wr_q.size(); i++)
      check("write", 32'(wr_q[base + i]), 32'(exp_wr[i]));
    check("final_vx", 32'(rf[ins[11:8]]), 32'(m_regs[ins[11:8]]));
    check("final_vf", 32'(rf[15]), 32'(m_regs[15]));
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; instr = 16'h8014;
    for (int i = 0; i < 16; i++) rf_init[i] = 8'(i * 17);
    repeat (2) @(posedge cpu_clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_we", 32'(reg_we), 32'd0);
    check("rst_addr", 32'(reg_addr), 32'd0);
    check("rst_wdata", 32'(reg_wdata), 32'd0);
    check("rst_in1", 32'(alu_in1), 32'd0);
    check("rst_in2", 32'(alu_in2), 32'd0);
    check("rst_sel", 32'(alu_sel), 32'(ALU_f_OR));
    start = 1'b0;
    @(negedge cpu_clk) reset = 1'b0;
    load_rf();

    rf_init[3] = 8'hF0; rf_init[5] = 8'h20; load_rf();
    run_op(16'h8354, 0);
    rf_init[1] = 8'h40; rf_init[2] = 8'h40; load_rf();
    run_op(16'h8125, 0);
    rf_init[1] = 8'h10; rf_init[2] = 8'h20; load_rf();
    run_op(16'h8125, 0);
    rf_init[15] = 8'h81; load_rf();
    run_op(16'h8F0E, 0);
    rf_init[10] = 8'h0F; rf_init[11] = 8'hF0; load_rf();
    run_op(16'h8AB1, 0);
    run_op(16'h8128, 0);
    run_op(16'h8674, 1);
    run_op(16'h8674, 2);
    run_op(16'h8127, 0);

    for (int t = 0; t < 60; t++) begin
      logic [15:0] ins;
      if (t % 8 == 0) begin
        for (int i = 0; i < 16; i++) rf_init[i] = 8'($urandom);
        load_rf();
      end
      ins = 16'($urandom);
      if ($urandom_range(9) != 0) ins[15:12] = 4'h8;
      run_op(ins, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chip8_alu_seq.md
CHIP8_ALU_SEQ -- requirements
Module: chip8_alu_seq

Interface
REQ-001 The block SHALL have port cpu_clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port start, input, 1 bit: request to execute instr; sampled only in IDLE.
REQ-004 The block SHALL have port instr, input, 16 bits: 8XYn opcode, latched on accepted start.
REQ-005 The block SHALL have ports busy, done and err, outputs, 1 bit each: operation in progress; one-cycle completion pulse; one-cycle illegal-opcode pulse coincident with done.
REQ-006 The block SHALL have port reg_addr, output, 4 bits: register-file read/write address.
REQ-007 The block SHALL have port reg_rdata, input, 8 bits: register-file read data, valid the cycle after reg_addr is presented (synchronous read).
REQ-008 The block SHALL have ports reg_wdata (output, 8 bits) and reg_we (output, 1 bit): register-file write, one write per reg_we cycle.
REQ-009 The block SHALL have ports alu_in1 and alu_in2 (outputs, 16 bits each) and alu_sel (output, ALU_f): drive the combinational ALU.
REQ-010 The block SHALL have ports alu_out (input, 16 bits) and alu_carry (input, 1 bit): ALU result and carry.

Function
REQ-011 The FSM SHALL have the states IDLE, RD_X, RD_Y, LATCH_Y, EXEC, WB_RES, WB_FLAG and DONE.
REQ-012 In IDLE with start=1, the block SHALL latch instr and go to DONE with err=1 if instr[15:12]!=8 or n is not in {0,1,2,3,4,5,6,7,E}, otherwise go to RD_X.
REQ-013 RD_X SHALL drive reg_addr=X; RD_Y SHALL drive reg_addr=Y and capture vx from reg_rdata at the cycle end; LATCH_Y SHALL capture vy.
REQ-014 In EXEC the block SHALL drive alu_in1/alu_in2 as the zero-extended operands and register res=alu_out[7:0] plus the flag value.
REQ-015 Operation n=0 SHALL give res=vy with no ALU use.
REQ-016 Operations n=1, 2, 3 SHALL use ALU_f_OR, ALU_f_AND and ALU_f_XOR (in1=vx, in2=vy).
REQ-017 Operation n=4 SHALL use ALU_f_ADD with flag=alu_carry.
REQ-018 Operation n=5 SHALL use ALU_f_MINUS with in1=vx, in2=vy and flag=(vx>=vy), computed locally.
REQ-019 Operation n=7 SHALL use ALU_f_MINUS with in1=vy, in2=vx and flag=(vy>=vx).
REQ-020 Operation n=6 SHALL use ALU_f_RSHIFT with in2=1 and flag=vx[0].
REQ-021 Operation n=E SHALL use ALU_f_LSHIFT with in2=1, res=alu_out[7:0] and flag=vx[7].
REQ-022 WB_RES SHALL assert reg_we for exactly one cycle, with reg_addr=X and reg_wdata=res.
REQ-023 For n in {4,5,6,7,E}, WB_FLAG SHALL assert reg_we with reg_addr=F and reg_wdata=0x01 or 0x00; for the other ops the FSM SHALL go directly from WB_RES to DONE.
REQ-024 Because VF is written after Vx, when X=F the flag value SHALL be the final VF contents.
REQ-025 Latency SHALL be: start sampled at edge E0, done high in the cycle after E7 for flag ops and after E6 for non-flag ops; an illegal opcode gives done+err in the cycle after E1.
REQ-026 busy SHALL be 1 from the cycle after an accepted start through DONE inclusive, and 0 otherwise.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 DONE SHALL return to IDLE unconditionally; the block SHALL not accept start in the DONE cycle.
REQ-029 Outside EXEC, alu_in1 and alu_in2 SHALL be 0 and alu_sel SHALL be ALU_f_OR.
REQ-030 reg_we SHALL be 0 in every state except WB_RES and WB_FLAG.
REQ-031 reg_wdata SHALL be 8 bits only; alu_out[15:8] SHALL be discarded.

Reset
REQ-032 On reset=1 at an edge, the FSM SHALL go to IDLE and busy, done, err, reg_we, reg_addr, reg_wdata, alu_in1 and alu_in2 SHALL be 0, with alu_sel=ALU_f_OR.
REQ-033 Reset mid-operation SHALL abort with no further reg_we; writes already completed SHALL remain.
REQ-034 Reset SHALL take priority over start in the same cycle.

Structure
REQ-035 ALU_f SHALL come from the shared enums.svh, and an FSM state enum SHALL be added there.
REQ-036 Operation-code constants (n values) SHALL be added to the shared enums.svh.
REQ-037 The block SHALL be a single module with no sub-modules; the ALU SHALL be instantiated beside it in the CPU, not inside it.
REQ-038 The FSM SHALL use one always_ff for state and registers and one always_comb for outputs.

Verification
REQ-039 The bench SHALL cover: V3=0xF0, V5=0x20, instr 0x8354 -> write V3=0x10, then VF=0x01; done in the cycle after E7.
REQ-040 The bench SHALL cover: V1=0x40, V2=0x40, instr 0x8125 -> V1=0x00, VF=0x01; V1=0x10, V2=0x20 -> V1=0xF0, VF=0x00.
REQ-041 The bench SHALL cover: VF=0x81, instr 0x8F0E -> write VF=0x02 then VF=0x01; final VF=0x01.
REQ-042 The bench SHALL cover: VA=0x0F, VB=0xF0, instr 0x8AB1 -> VA=0xFF, no VF write; done in the cycle after E6.
REQ-043 The bench SHALL cover: instr 0x8128 -> done=err=1 in the cycle after E1; reg_we never asserted.
REQ-044 The bench SHALL cover: start pulsed during RD_Y ignored; reset asserted in EXEC -> IDLE, busy=0 next cycle, no reg_we.
